// File: rtl/axi_wr_arbiter_2to1.sv
// Two-master to one-slave AXI4 write arbiter: round-robin AW grants, W routed in
// grant order through a small order FIFO, B routed back by the low AWID bit.
module axi_wr_arbiter_2to1 #(
  parameter int unsigned DW          = 512,
  parameter int unsigned ORDER_DEPTH = 16
) (
  input  logic            clk,
  input  logic            sys_resetn,

  input  logic [63:0]     S0_AXI_AWADDR,
  input  logic [7:0]      S0_AXI_AWLEN,
  input  logic            S0_AXI_AWVALID,
  output logic            S0_AXI_AWREADY,
  input  logic [DW-1:0]   S0_AXI_WDATA,
  input  logic            S0_AXI_WVALID,
  input  logic            S0_AXI_WLAST,
  output logic            S0_AXI_WREADY,
  output logic [1:0]      S0_AXI_BRESP,
  output logic            S0_AXI_BVALID,
  input  logic            S0_AXI_BREADY,

  input  logic [63:0]     S1_AXI_AWADDR,
  input  logic [7:0]      S1_AXI_AWLEN,
  input  logic            S1_AXI_AWVALID,
  output logic            S1_AXI_AWREADY,
  input  logic [DW-1:0]   S1_AXI_WDATA,
  input  logic            S1_AXI_WVALID,
  input  logic            S1_AXI_WLAST,
  output logic            S1_AXI_WREADY,
  output logic [1:0]      S1_AXI_BRESP,
  output logic            S1_AXI_BVALID,
  input  logic            S1_AXI_BREADY,

  output logic [63:0]     M_AXI_AWADDR,
  output logic [7:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [1:0]      M_AXI_AWBURST,
  output logic [3:0]      M_AXI_AWID,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WVALID,
  output logic            M_AXI_WLAST,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic [3:0]      M_AXI_BID,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,

  output logic [31:0]     grants0,
  output logic [31:0]     grants1,
  output logic            bad_bid
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = $clog2(ORDER_DEPTH);

  typedef enum logic [0:0] {StArb, StIssue} state_e;

  state_e           state_q, state_d;
  logic [ORDER_DEPTH-1:0] ord_mem_q;
  logic [PW:0]      wr_ptr_q, rd_ptr_q;
  logic             fifo_empty, fifo_full, push, pop, head;
  logic             last_grant_q, grant, winner;
  logic [63:0]      awaddr_q;
  logic [7:0]       awlen_q;
  logic             awid_q;
  logic [31:0]      grants0_q, grants1_q;
  logic             bad_bid_q;

  // Extra pointer bit distinguishes full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == (PW+1)'(ORDER_DEPTH));
  assign head       = ord_mem_q[rd_ptr_q[PW-1:0]];
  assign push       = grant;
  assign pop        = M_AXI_WVALID & M_AXI_WREADY & M_AXI_WLAST;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    winner  = 1'b0;
    unique case (state_q)
      StArb: begin
        if (!fifo_full && (S0_AXI_AWVALID || S1_AXI_AWVALID)) begin
          grant   = 1'b1;
          winner  = (S0_AXI_AWVALID && S1_AXI_AWVALID) ? ~last_grant_q : S1_AXI_AWVALID;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (M_AXI_AWREADY) state_d = StArb;
      end
      default: state_d = StArb;
    endcase
  end

  // Gated by reset so no handshake is offered while state is being held clear.
  assign S0_AXI_AWREADY = grant & ~winner & sys_resetn;
  assign S1_AXI_AWREADY = grant & winner & sys_resetn;

  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q      <= StArb;
      ord_mem_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_grant_q <= 1'b1;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      awid_q       <= 1'b0;
      grants0_q    <= '0;
      grants1_q    <= '0;
      bad_bid_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        ord_mem_q[wr_ptr_q[PW-1:0]] <= winner;
        wr_ptr_q     <= wr_ptr_q + 1'b1;
        last_grant_q <= winner;
        awaddr_q     <= winner ? S1_AXI_AWADDR : S0_AXI_AWADDR;
        awlen_q      <= winner ? S1_AXI_AWLEN : S0_AXI_AWLEN;
        awid_q       <= winner;
        if (winner) grants1_q <= grants1_q + 32'd1;
        else        grants0_q <= grants0_q + 32'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (M_AXI_BVALID && (M_AXI_BID[3:1] != 3'b000)) bad_bid_q <= 1'b1;
    end
  end

  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = awlen_q;
  assign M_AXI_AWSIZE  = 3'($clog2(SW));
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWID    = {3'b000, awid_q};
  assign M_AXI_AWVALID = (state_q == StIssue);
  assign M_AXI_WSTRB   = '1;
  assign grants0       = grants0_q;
  assign grants1       = grants1_q;
  assign bad_bid       = bad_bid_q;

  always_comb begin
    M_AXI_WVALID  = 1'b0;
    M_AXI_WDATA   = S0_AXI_WDATA;
    M_AXI_WLAST   = 1'b0;
    S0_AXI_WREADY = 1'b0;
    S1_AXI_WREADY = 1'b0;
    if (!fifo_empty) begin
      if (head) begin
        M_AXI_WVALID  = S1_AXI_WVALID;
        M_AXI_WDATA   = S1_AXI_WDATA;
        M_AXI_WLAST   = S1_AXI_WLAST;
        S1_AXI_WREADY = M_AXI_WREADY;
      end else begin
        M_AXI_WVALID  = S0_AXI_WVALID;
        M_AXI_WDATA   = S0_AXI_WDATA;
        M_AXI_WLAST   = S0_AXI_WLAST;
        S0_AXI_WREADY = M_AXI_WREADY;
      end
    end
  end

  assign S0_AXI_BVALID = M_AXI_BVALID & ~M_AXI_BID[0];
  assign S1_AXI_BVALID = M_AXI_BVALID & M_AXI_BID[0];
  assign S0_AXI_BRESP  = M_AXI_BRESP;
  assign S1_AXI_BRESP  = M_AXI_BRESP;
  assign M_AXI_BREADY  = M_AXI_BID[0] ? S1_AXI_BREADY : S0_AXI_BREADY;

endmodule

// File: tb/tb_axi_wr_arbiter_2to1.sv
// Randomized bench for axi_wr_arbiter_2to1 against a queue-based model of the
// grant order, W routing and B routing.
module tb_axi_wr_arbiter_2to1;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic sys_resetn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][63:0]   awaddr;
  logic [1:0][7:0]    awlen;
  logic [1:0]         awvalid, awready;
  logic [1:0][DW-1:0] wdata;
  logic [1:0]         wvalid, wlast, wready;
  logic [1:0][1:0]    bresp;
  logic [1:0]         bvalid, bready;

  logic [63:0]     m_awaddr;
  logic [7:0]      m_awlen;
  logic [2:0]      m_awsize;
  logic [1:0]      m_awburst;
  logic [3:0]      m_awid;
  logic            m_awvalid, m_awready;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_wvalid, m_wlast, m_wready;
  logic [1:0]      m_bresp;
  logic [3:0]      m_bid;
  logic            m_bvalid, m_bready;
  logic [31:0]     grants0, grants1;
  logic            bad_bid;

  axi_wr_arbiter_2to1 #(.DW(DW), .ORDER_DEPTH(DEPTH)) dut (
    .clk(clk), .sys_resetn(sys_resetn),
    .S0_AXI_AWADDR(awaddr[0]), .S0_AXI_AWLEN(awlen[0]), .S0_AXI_AWVALID(awvalid[0]),
    .S0_AXI_AWREADY(awready[0]), .S0_AXI_WDATA(wdata[0]), .S0_AXI_WVALID(wvalid[0]),
    .S0_AXI_WLAST(wlast[0]), .S0_AXI_WREADY(wready[0]), .S0_AXI_BRESP(bresp[0]),
    .S0_AXI_BVALID(bvalid[0]), .S0_AXI_BREADY(bready[0]),
    .S1_AXI_AWADDR(awaddr[1]), .S1_AXI_AWLEN(awlen[1]), .S1_AXI_AWVALID(awvalid[1]),
    .S1_AXI_AWREADY(awready[1]), .S1_AXI_WDATA(wdata[1]), .S1_AXI_WVALID(wvalid[1]),
    .S1_AXI_WLAST(wlast[1]), .S1_AXI_WREADY(wready[1]), .S1_AXI_BRESP(bresp[1]),
    .S1_AXI_BVALID(bvalid[1]), .S1_AXI_BREADY(bready[1]),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWLEN(m_awlen), .M_AXI_AWSIZE(m_awsize),
    .M_AXI_AWBURST(m_awburst), .M_AXI_AWID(m_awid), .M_AXI_AWVALID(m_awvalid),
    .M_AXI_AWREADY(m_awready), .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb),
    .M_AXI_WVALID(m_wvalid), .M_AXI_WLAST(m_wlast), .M_AXI_WREADY(m_wready),
    .M_AXI_BRESP(m_bresp), .M_AXI_BID(m_bid), .M_AXI_BVALID(m_bvalid),
    .M_AXI_BREADY(m_bready), .grants0(grants0), .grants1(grants1), .bad_bid(bad_bid)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: grant order queue plus the AW issue slot.
  bit          m_last;
  bit          m_issue;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  bit          m_id;
  bit          ord_q[$];
  int unsigned m_g[2];
  bit          m_bad;

  // Per-cycle handshake outcomes predicted by the model.
  bit          g_fire, g_src, pop_fire, w_fire, w_src;
  logic [1:0]  obs_awr;

  // Master-side bookkeeping: burst lengths in each master's own AW order.
  int wlen[2][64];
  int whead[2], wtail[2], wbeat[2];

  logic [1:0] req_en;
  int req_pct, w_pct, aw_mode, wr_mode;
  bit rand_b;

  task automatic check_cycle();
    logic [1:0] exp_awr, exp_wr, exp_bv;
    bit h;
    exp_awr = '0; exp_wr = '0; exp_bv = '0;
    g_fire = 0; g_src = 0; pop_fire = 0; w_fire = 0; w_src = 0;
    if (sys_resetn && !m_issue && ord_q.size() < DEPTH && awvalid != 2'b00) begin
      g_src  = (awvalid == 2'b11) ? ~m_last : awvalid[1];
      g_fire = 1;
      exp_awr[g_src] = 1'b1;
    end
    obs_awr = awready;
    chk("s_awready", 64'(awready), 64'(exp_awr));
    chk("m_awvalid", 64'(m_awvalid), 64'(m_issue));
    if (m_issue) begin
      chk("m_awaddr", m_awaddr, m_addr);
      chk("m_awlen", 64'(m_awlen), 64'(m_len));
      chk("m_awid", 64'(m_awid), 64'(m_id));
    end
    chk("m_awsize", 64'(m_awsize), 64'd2);
    chk("m_awburst", 64'(m_awburst), 64'd1);
    chk("m_wstrb", 64'(m_wstrb), 64'hF);
    if (ord_q.size() == 0) begin
      chk("m_wvalid_empty", 64'(m_wvalid), 64'd0);
    end else begin
      h = ord_q[0];
      chk("m_wvalid", 64'(m_wvalid), 64'(wvalid[h]));
      if (wvalid[h]) begin
        chk("m_wdata", 64'(m_wdata), 64'(wdata[h]));
        chk("m_wlast", 64'(m_wlast), 64'(wlast[h]));
      end
      exp_wr[h] = m_wready;
      w_fire    = wvalid[h] && m_wready;
      w_src     = h;
      pop_fire  = w_fire && wlast[h];
    end
    chk("s_wready", 64'(wready), 64'(exp_wr));
    exp_bv[m_bid[0]] = m_bvalid;
    chk("s_bvalid", 64'(bvalid), 64'(exp_bv));
    chk("m_bready", 64'(m_bready), 64'(bready[m_bid[0]]));
    chk("s_bresp", 64'(bresp), 64'({m_bresp, m_bresp}));
    chk("grants0", 64'(grants0), 64'(m_g[0]));
    chk("grants1", 64'(grants1), 64'(m_g[1]));
    chk("bad_bid", 64'(bad_bid), 64'(m_bad));
  endtask

  task automatic apply_model();
    if (!sys_resetn) return;
    if (pop_fire) void'(ord_q.pop_front());
    if (g_fire) begin
      ord_q.push_back(g_src);
      m_issue = 1;
      m_addr  = awaddr[g_src];
      m_len   = awlen[g_src];
      m_id    = g_src;
      m_last  = g_src;
      m_g[g_src]++;
    end else if (m_issue && m_awready) begin
      m_issue = 0;
    end
    if (m_bvalid && m_bid[3:1] != 3'b000) m_bad = 1;
  endtask

  task automatic new_req(input int s);
    awvalid[s] = 1'b1;
    awaddr[s]  = {$urandom, $urandom};
    awlen[s]   = 8'($urandom_range(3));
    wlen[s][wtail[s] % 64] = int'(awlen[s]);
    wtail[s]++;
  endtask

  task automatic drive();
    for (int s = 0; s < 2; s++) begin
      if (g_fire && int'(g_src) == s) awvalid[s] = 1'b0;
      if (!awvalid[s] && req_en[s] && (wtail[s] - whead[s]) < 40 &&
          $urandom_range(99) < req_pct) new_req(s);
      if (w_fire && int'(w_src) == s) begin
        if (wbeat[s] == wlen[s][whead[s] % 64]) begin
          whead[s]++;
          wbeat[s] = 0;
        end else begin
          wbeat[s]++;
        end
        wvalid[s] = 1'b0;
      end
      if (!wvalid[s] && whead[s] != wtail[s] && $urandom_range(99) < w_pct) begin
        wvalid[s] = 1'b1;
        wdata[s]  = DW'($urandom);
        wlast[s]  = (wbeat[s] == wlen[s][whead[s] % 64]);
      end
    end
    m_awready = (aw_mode == 1) ? 1'b1 : 1'($urandom_range(1));
    case (wr_mode)
      1:       m_wready = 1'b0;
      2:       m_wready = 1'b1;
      default: m_wready = 1'($urandom_range(1));
    endcase
    if (rand_b) begin
      m_bvalid = 1'($urandom_range(1));
      m_bid    = 4'($urandom_range(1));
      m_bresp  = 2'($urandom);
      bready   = 2'($urandom);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    apply_model();
    #1;
    drive();
  endtask

  task automatic model_reset();
    m_last = 1; m_issue = 0; ord_q.delete(); m_g[0] = 0; m_g[1] = 0; m_bad = 0;
    awvalid = '0; wvalid = '0; wlast = '0;
    for (int s = 0; s < 2; s++) begin
      whead[s] = 0; wtail[s] = 0; wbeat[s] = 0;
    end
  endtask

  task automatic drain();
    int i;
    req_en = 2'b00; wr_mode = 2; w_pct = 100;
    for (i = 0; i < 500; i++) begin
      if (ord_q.size() == 0 && !m_issue && awvalid == 2'b00 &&
          whead[0] == wtail[0] && whead[1] == wtail[1]) break;
      step();
    end
    chk("drain_bound", 64'(i < 500), 64'd1);
  endtask

  initial begin
    int base;
    int i;
    awaddr = '0; awlen = '0; wdata = '0; bready = '0;
    m_awready = 0; m_wready = 0; m_bresp = 0; m_bid = 0; m_bvalid = 0;
    req_en = 2'b00; req_pct = 50; w_pct = 70; aw_mode = 0; wr_mode = 0; rand_b = 1;
    model_reset();

    for (i = 0; i < 3; i++) step();
    sys_resetn = 1'b1;

    // Only S0 requests.
    req_en = 2'b01;
    for (i = 0; i < 200; i++) step();
    chk("s0_only_grants1", 64'(grants1), 64'd0);
    drain();

    // Both masters, random traffic, W often offered before the AW grant.
    req_en = 2'b11; wr_mode = 0; w_pct = 70;
    for (i = 0; i < 1500; i++) step();

    // Continuous contention must alternate.
    drain();
    req_en = 2'b11; req_pct = 100; aw_mode = 1; wr_mode = 2;
    for (i = 0; i < 40; i++) step();
    req_pct = 50; aw_mode = 0;
    drain();

    // Order FIFO capacity with W stalled.
    base = int'(m_g[0] + m_g[1]);
    req_en = 2'b11; req_pct = 100; aw_mode = 1; wr_mode = 1; w_pct = 100;
    for (i = 0; i < 100; i++) step();
    chk("cap_grants", 64'(grants0 + grants1), 64'(base + DEPTH));
    wr_mode = 2; m_wready = 1'b1;
    for (i = 0; i < 50; i++) begin
      step();
      if (pop_fire) break;
    end
    wr_mode = 1; m_wready = 1'b0;
    chk("cap_pop_bound", 64'(i < 50), 64'd1);
    for (i = 0; i < 50; i++) step();
    chk("cap_plus_one", 64'(grants0 + grants1), 64'(base + DEPTH + 1));
    req_pct = 50; aw_mode = 0;
    drain();

    // B routing and sticky bad_bid.
    req_en = 2'b11; wr_mode = 0; w_pct = 70; rand_b = 0;
    m_bvalid = 1'b1; m_bresp = 2'b10; bready = 2'b10;
    m_bid = 4'd1; step();
    m_bid = 4'd0; bready = 2'b01; m_bresp = 2'b01; step();
    m_bid = 4'd2; step();
    m_bvalid = 1'b0; m_bid = 4'd0;
    for (i = 0; i < 5; i++) step();
    chk("bad_sticky", 64'(bad_bid), 64'd1);
    rand_b = 1;
    for (i = 0; i < 30; i++) step();

    // Reset while an AW is being issued.
    for (i = 0; i < 200; i++) begin
      step();
      if (m_issue) break;
    end
    chk("issue_bound", 64'(m_issue), 64'd1);
    m_awready = 1'b0;
    #1;
    chk("pre_reset_awvalid", 64'(m_awvalid), 64'd1);
    sys_resetn = 1'b0;
    #1;
    chk("reset_awvalid", 64'(m_awvalid), 64'd0);
    chk("reset_wvalid", 64'(m_wvalid), 64'd0);
    chk("reset_bad_bid", 64'(bad_bid), 64'd0);
    req_en = 2'b00;
    model_reset();
    for (i = 0; i < 3; i++) step();
    sys_resetn = 1'b1;
    new_req(0);
    new_req(1);
    req_en = 2'b11;
    step();
    chk("tie_after_reset", 64'(obs_awr), 64'd1);
    for (i = 0; i < 200; i++) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter_2to1.md
Name: axi_wr_arbiter_2to1

Overview:
- Shares one AXI4 write port (AW/W/B) to the RAM controller between two stream_to_ram-style write masters (channel 0 and channel 1).
- AW requests are arbitrated round-robin. The W channel is routed in AW-grant order through an internal order FIFO. B responses are routed back by AWID.
- Read channels are not handled; each master's read port is tied off elsewhere.

Parameters:
- DW, 512, data width in bits; WSTRB width is DW/8.
- ORDER_DEPTH, 16, maximum number of granted bursts whose W data has not yet completed; power of 2.

Ports:
- clk  in  1  sole clock.
- sys_resetn  in  1  asynchronous, active-low reset.
- S0_/S1_AXI_AWADDR  in  64  requester burst address.
- S0_/S1_AXI_AWLEN  in  8  requester burst length-1.
- S0_/S1_AXI_AWVALID  in  1  requester AW valid.
- S0_/S1_AXI_AWREADY  out  1  requester AW accepted.
- S0_/S1_AXI_WDATA  in  DW  requester write data.
- S0_/S1_AXI_WVALID  in  1  requester W valid.
- S0_/S1_AXI_WLAST  in  1  requester last beat.
- S0_/S1_AXI_WREADY  out  1  requester W ready.
- S0_/S1_AXI_BRESP  out  2  response to requester.
- S0_/S1_AXI_BVALID  out  1  response valid.
- S0_/S1_AXI_BREADY  in  1  requester response ready.
- M_AXI_AWADDR  out  64  granted address.
- M_AXI_AWLEN  out  8  granted length.
- M_AXI_AWSIZE  out  3  constant $clog2(DW/8).
- M_AXI_AWBURST  out  2  constant 1 (INCR).
- M_AXI_AWID  out  4  {3'b000, source index}.
- M_AXI_AWVALID  out  1.
- M_AXI_AWREADY  in  1.
- M_AXI_WDATA  out  DW.
- M_AXI_WSTRB  out  DW/8  constant all ones.
- M_AXI_WVALID  out  1.
- M_AXI_WLAST  out  1.
- M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2.
- M_AXI_BID  in  4.
- M_AXI_BVALID  in  1.
- M_AXI_BREADY  out  1.
- grants0, grants1  out  32 each  count of AWs granted per source.
- bad_bid  out  1  sticky; set when a B arrives with BID[3:1] != 0.

Behaviour:
Reset
- sys_resetn low asynchronously clears all state.
- Output values during reset: M_AXI_AWVALID=0, both S AWREADY=0, order FIFO empty, last_grant=1 (so S0 wins the first tie), grants0=grants1=0, bad_bid=0.
- Reset mid-burst abandons all outstanding bursts; no recovery is attempted.

AW state machine
- States: ARB, ISSUE.
- ARB:
  - A grant may be made when the order FIFO is not full and at least one S AWVALID is high.
  - Source selection: if only one S AWVALID is high, that source wins. If both are high, the source != last_grant wins.
  - On the grant cycle: pulse the winner's AWREADY for exactly 1 cycle; register its AWADDR/AWLEN into the M_AXI AW registers; set AWID; push the source index into the order FIFO; increment grantsN; update last_grant; go to ISSUE.
- ISSUE:
  - M_AXI_AWVALID=1, with address, length and ID stable.
  - On M_AXI_AWREADY, return to ARB.
  - Throughput is therefore at most one grant per 2 cycles. Latency from S AWVALID to M AWVALID is 1 cycle.
- Full order FIFO: remain in ARB with both AWREADY low.

W routing (combinational, driven by the order FIFO head)
- Order FIFO empty: M_AXI_WVALID=0 and both S WREADY=0.
- Otherwise, with head h:
  - M_AXI_WDATA/WLAST/WVALID = Sh values.
  - Sh_WREADY = M_AXI_WREADY.
  - The other source's WREADY = 0.
- Pop the FIFO on M_AXI_WVALID & M_AXI_WREADY & M_AXI_WLAST.
- A push and a pop in the same cycle leave the FIFO count unchanged.
- W beats are never forwarded ahead of their AW grant.

B routing (combinational)
- BID[0] selects the target source.
- S(BID[0])_BVALID = M_AXI_BVALID; the other source's BVALID = 0.
- BRESP is passed through.
- M_AXI_BREADY = S(BID[0])_BREADY.
- bad_bid is set on M_AXI_BVALID with BID[3:1] != 0; only reset clears it.

Counters
- grants0/grants1 wrap modulo 2^32.

Test Plan:
- Only S0 issues 4 AWs of AWLEN=3 with W data; S1 idle -> 4 M AWs with AWID=0, 16 W beats in order, 4 B routed to S0; grants0=4, grants1=0.
- S0 and S1 both hold AWVALID continuously for 6 grants -> M AWIDs are 0,1,0,1,0,1; W bursts forwarded in that exact order; grants0=grants1=3.
- S1 presents W data before its AW is granted while S0's burst is in progress -> S1_WREADY stays 0 until S0's WLAST is accepted and S1's entry reaches the order FIFO head.
- ORDER_DEPTH=16 with M_AXI_WREADY held 0 -> exactly 16 grants, then both S AWREADY stay 0; releasing WREADY for one burst (pop) allows exactly 1 more grant.
- B stimulus BID=1, then BID=0, then BID=2 -> first response goes to S1, second to S0; BID=2 sets bad_bid=1 and bad_bid remains 1 until reset.
- Deassert sys_resetn mid-burst with M_AXI_AWVALID=1 -> M_AXI_AWVALID and M_AXI_WVALID drop immediately; after release, the first tie is granted to S0.
